// File: rtl/regfile_if.sv
// rtl/regfile_if.sv - decode/write-back bus of the integer register file
// Purpose: bundles the write-back write port, the two decode read ports,
//          the debug read port and the committed-write counter of regfile.
// Signals:
//   we_i, waddr_i, wdata_i          write request from write-back
//   reg1_re_i, reg1_raddr_i         port-1 read request from decode
//   reg1_rdata_o                    port-1 read data
//   reg2_re_i, reg2_raddr_i         port-2 read request from decode
//   reg2_rdata_o                    port-2 read data
//   dbg_raddr_i, dbg_rdata_o        debug read (stored value, no bypass)
//   wr_cnt_o                        effective writes since reset
// Modports: master = pipeline side, slave = register file side.
interface regfile_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 64
);
   logic              we_i;
   logic [ADDR_W-1:0] waddr_i;
   logic [DATA_W-1:0] wdata_i;

   logic              reg1_re_i;
   logic [ADDR_W-1:0] reg1_raddr_i;
   logic [DATA_W-1:0] reg1_rdata_o;

   logic              reg2_re_i;
   logic [ADDR_W-1:0] reg2_raddr_i;
   logic [DATA_W-1:0] reg2_rdata_o;

   logic [ADDR_W-1:0] dbg_raddr_i;
   logic [DATA_W-1:0] dbg_rdata_o;

   logic [CNT_W-1:0]  wr_cnt_o;

   modport master (
      output we_i, waddr_i, wdata_i,
      output reg1_re_i, reg1_raddr_i,
      output reg2_re_i, reg2_raddr_i,
      output dbg_raddr_i,
      input  reg1_rdata_o, reg2_rdata_o, dbg_rdata_o, wr_cnt_o
   );

   modport slave (
      input  we_i, waddr_i, wdata_i,
      input  reg1_re_i, reg1_raddr_i,
      input  reg2_re_i, reg2_raddr_i,
      input  dbg_raddr_i,
      output reg1_rdata_o, reg2_rdata_o, dbg_rdata_o, wr_cnt_o
   );
endinterface

// File: rtl/regfile.sv
// rtl/regfile.sv - 32-entry integer register file with write-back bypass
// Purpose: architectural integer registers of the in-order pipeline. Two
//          combinational decode read ports with write-first bypass from the
//          write-back port, hard-wired x0, a non-bypassed debug read port and
//          a wrapping count of effective (committed) writes.
// Ports:
//   clk_i   clock, all state updates on the rising edge
//   rst_i   asynchronous active-low reset; clears registers and counter and
//           forces every read output to 0 while low
//   rf      regfile_if.slave bus (write, two reads, debug read, counter)
// The DATA_W/ADDR_W/CNT_W values must match those of the connected interface.
module regfile #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 64
) (
   input  logic       clk_i,
   input  logic       rst_i,
   regfile_if.slave   rf
);

   localparam int NREGS = 1 << ADDR_W;

   // Entry 0 is never written, so it stays at its reset value of 0 and the
   // synthesiser can drop it; reads of x0 are also gated explicitly below.
   logic [DATA_W-1:0] regs [NREGS];
   logic [CNT_W-1:0]  wr_cnt_q;

   logic              wr_eff;
   logic [DATA_W-1:0] reg1_stored;
   logic [DATA_W-1:0] reg2_stored;
   logic [DATA_W-1:0] dbg_stored;
   logic              reg1_byp;
   logic              reg2_byp;

   // x0 writes are dropped entirely, including the counter increment.
   assign wr_eff = rf.we_i && (rf.waddr_i != '0);

   // ------------------------------------------------------------------
   // Write port and committed-write counter
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
         wr_cnt_q <= '0;
      end else if (wr_eff) begin
         regs[rf.waddr_i] <= rf.wdata_i;
         wr_cnt_q         <= wr_cnt_q + CNT_W'(1);
      end
   end

   assign rf.wr_cnt_o = wr_cnt_q;

   // ------------------------------------------------------------------
   // Read ports
   // ------------------------------------------------------------------
   assign reg1_stored = regs[rf.reg1_raddr_i];
   assign reg2_stored = regs[rf.reg2_raddr_i];
   assign dbg_stored  = regs[rf.dbg_raddr_i];

   // Bypass only needs an address match; a zero read address is already
   // forced to 0 ahead of the bypass, so a write to x0 can never leak out.
   assign reg1_byp = rf.we_i && (rf.waddr_i == rf.reg1_raddr_i);
   assign reg2_byp = rf.we_i && (rf.waddr_i == rf.reg2_raddr_i);

   always_comb begin
      rf.reg1_rdata_o = '0;
      if (rst_i && rf.reg1_re_i && (rf.reg1_raddr_i != '0)) begin
         rf.reg1_rdata_o = reg1_byp ? rf.wdata_i : reg1_stored;
      end
   end

   always_comb begin
      rf.reg2_rdata_o = '0;
      if (rst_i && rf.reg2_re_i && (rf.reg2_raddr_i != '0)) begin
         rf.reg2_rdata_o = reg2_byp ? rf.wdata_i : reg2_stored;
      end
   end

   // Debug sees committed state only: no enable, no bypass.
   always_comb begin
      rf.dbg_rdata_o = '0;
      if (rst_i && (rf.dbg_raddr_i != '0)) begin
         rf.dbg_rdata_o = dbg_stored;
      end
   end

endmodule

// File: tb/tb_regfile.sv
// tb/tb_regfile.sv - randomized self-checking bench for regfile
module tb_regfile;

   logic        clk;
   logic        rst_n;
   logic        we;
   logic [4:0]  waddr;
   logic [63:0] wdata;
   logic        re1;
   logic [4:0]  raddr1;
   logic        re2;
   logic [4:0]  raddr2;
   logic [4:0]  dbg_addr;

   int checks   = 0;
   int failures = 0;

   // Reference state: plain array of register values and an unbounded count.
   logic [63:0]     mdl [32];
   longint unsigned cnt64;

   regfile_if #(.DATA_W(64), .ADDR_W(5), .CNT_W(64)) bus  ();
   regfile_if #(.DATA_W(64), .ADDR_W(5), .CNT_W(4))  bus4 ();

   assign bus.we_i          = we;
   assign bus.waddr_i       = waddr;
   assign bus.wdata_i       = wdata;
   assign bus.reg1_re_i     = re1;
   assign bus.reg1_raddr_i  = raddr1;
   assign bus.reg2_re_i     = re2;
   assign bus.reg2_raddr_i  = raddr2;
   assign bus.dbg_raddr_i   = dbg_addr;

   assign bus4.we_i         = we;
   assign bus4.waddr_i      = waddr;
   assign bus4.wdata_i      = wdata;
   assign bus4.reg1_re_i    = re1;
   assign bus4.reg1_raddr_i = raddr1;
   assign bus4.reg2_re_i    = re2;
   assign bus4.reg2_raddr_i = raddr2;
   assign bus4.dbg_raddr_i  = dbg_addr;

   regfile #(.DATA_W(64), .ADDR_W(5), .CNT_W(64)) dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .rf    (bus)
   );

   regfile #(.DATA_W(64), .ADDR_W(5), .CNT_W(4)) dut4 (
      .clk_i (clk),
      .rst_i (rst_n),
      .rf    (bus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] exp_rd(input logic re, input logic [4:0] a);
      if (!rst_n || !re || a == 5'd0) return 64'd0;
      if (we && waddr == a) return wdata;
      return mdl[a];
   endfunction

   // Model: reset clears everything, an effective write updates one entry.
   always @(negedge rst_n) begin
      for (int i = 0; i < 32; i++) mdl[i] = 64'd0;
      cnt64 = 0;
   end

   always @(posedge clk) begin
      if (rst_n === 1'b1 && we && waddr != 5'd0) begin
         mdl[waddr] = wdata;
         cnt64      = cnt64 + 1;
      end
   end

   // Compare process: every output is meaningful on every cycle.
   always @(negedge clk) begin
      check("rd1",     bus.reg1_rdata_o,  exp_rd(re1, raddr1));
      check("rd2",     bus.reg2_rdata_o,  exp_rd(re2, raddr2));
      check("dbg",     bus.dbg_rdata_o,   rst_n ? mdl[dbg_addr] : 64'd0);
      check("wr_cnt",  bus.wr_cnt_o,      cnt64);
      check("rd1_c4",  bus4.reg1_rdata_o, exp_rd(re1, raddr1));
      check("wr_cnt4", {60'd0, bus4.wr_cnt_o}, {60'd0, cnt64[3:0]});
   end

   task automatic idle();
      we = 1'b0; waddr = '0; wdata = '0;
      re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0; dbg_addr = '0;
   endtask

   // Advance to 1 time unit after the next rising edge, where inputs change.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Mid-cycle reset pulse: asserted at posedge+3, released at posedge+7.
   task automatic reset_pulse();
      @(posedge clk);
      #3 rst_n = 1'b0;
      #4 rst_n = 1'b1;
   endtask

   logic [63:0] prev;
   logic [63:0] val;

   initial begin
      for (int i = 0; i < 32; i++) mdl[i] = 64'd0;
      cnt64 = 0;
      idle();
      rst_n = 1'b0;
      re1 = 1'b1; raddr1 = 5'd5;
      #23 rst_n = 1'b1;

      // Reset state
      @(negedge clk);
      check("reset_rd1", bus.reg1_rdata_o, 64'd0);
      check("reset_cnt", bus.wr_cnt_o, 64'd0);

      // 1. write x5, then mid-cycle reset
      step(); we = 1'b1; waddr = 5'd5; wdata = 64'hDEAD;
      step(); idle(); re1 = 1'b1; raddr1 = 5'd5;
      @(negedge clk);
      check("t1_before", bus.reg1_rdata_o, 64'hDEAD);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check("t1_rd1_in_reset", bus.reg1_rdata_o, 64'd0);
      check("t1_cnt_in_reset", bus.wr_cnt_o, 64'd0);
      #3 rst_n = 1'b1;
      step(); idle(); dbg_addr = 5'd5;
      @(negedge clk);
      check("t1_dbg_after", bus.dbg_rdata_o, 64'd0);

      // 2. write/readback
      step(); we = 1'b1; waddr = 5'd3; wdata = 64'h1234_5678_9ABC_DEF0;
      step(); idle(); re1 = 1'b1; raddr1 = 5'd3;
      @(negedge clk);
      check("t2_rd1", bus.reg1_rdata_o, 64'h1234_5678_9ABC_DEF0);
      check("t2_cnt", bus.wr_cnt_o, 64'd1);

      // 3. bypass on both ports, debug sees stored value
      step(); idle(); we = 1'b1; waddr = 5'd7; wdata = 64'h11;
      step(); we = 1'b1; waddr = 5'd7; wdata = 64'h22;
      re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd7; dbg_addr = 5'd7;
      @(negedge clk);
      check("t3_rd1_byp", bus.reg1_rdata_o, 64'h22);
      check("t3_rd2_byp", bus.reg2_rdata_o, 64'h22);
      check("t3_dbg_old", bus.dbg_rdata_o, 64'h11);
      step(); idle(); dbg_addr = 5'd7;
      @(negedge clk);
      check("t3_dbg_new", bus.dbg_rdata_o, 64'h22);

      // 4. x0 writes are discarded
      step(); we = 1'b1; waddr = 5'd0; wdata = 64'hFFFF;
      re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd0; dbg_addr = 5'd0;
      @(negedge clk);
      check("t4_rd1", bus.reg1_rdata_o, 64'd0);
      check("t4_rd2", bus.reg2_rdata_o, 64'd0);
      step(); idle(); dbg_addr = 5'd0;
      @(negedge clk);
      check("t4_dbg", bus.dbg_rdata_o, 64'd0);
      check("t4_cnt", bus.wr_cnt_o, 64'd3);

      // 5. read-enable gating, enable raised mid-cycle
      step(); we = 1'b1; waddr = 5'd9; wdata = 64'h55;
      step(); idle(); re2 = 1'b0; raddr2 = 5'd9;
      @(negedge clk);
      check("t5_gated", bus.reg2_rdata_o, 64'd0);
      #1 re2 = 1'b1;
      #1 check("t5_enabled", bus.reg2_rdata_o, 64'h55);

      // 6. counter wrap on the CNT_W=4 build, then back-to-back x31 writes
      reset_pulse();
      for (int i = 1; i <= 17; i++) begin
         step(); idle(); we = 1'b1; waddr = 5'(i); wdata = {$urandom, $urandom};
      end
      step(); idle();
      @(negedge clk);
      check("t6_cnt4_wrap", {60'd0, bus4.wr_cnt_o}, 64'd1);
      check("t6_cnt64", bus.wr_cnt_o, 64'd17);
      prev = 64'd0;
      for (int k = 0; k < 6; k++) begin
         val = (k % 2 == 0) ? 64'hA : 64'hB;
         step(); idle(); we = 1'b1; waddr = 5'd31; wdata = val;
         re1 = 1'b1; raddr1 = 5'd31; dbg_addr = 5'd31;
         @(negedge clk);
         check("t6_byp", bus.reg1_rdata_o, val);
         check("t6_stored_prev", bus.dbg_rdata_o, prev);
         prev = val;
      end
      step(); idle(); re1 = 1'b1; raddr1 = 5'd31;
      @(negedge clk);
      check("t6_final", bus.reg1_rdata_o, 64'hB);

      // Randomized traffic; addresses narrowed half the time for collisions.
      for (int n = 0; n < 2000; n++) begin
         step();
         if ($urandom_range(0, 1) == 0) begin
            waddr  = 5'($urandom_range(0, 3));
            raddr1 = 5'($urandom_range(0, 3));
            raddr2 = 5'($urandom_range(0, 3));
         end else begin
            waddr  = 5'($urandom_range(0, 31));
            raddr1 = 5'($urandom_range(0, 31));
            raddr2 = 5'($urandom_range(0, 31));
         end
         we       = ($urandom_range(0, 3) != 0);
         wdata    = {$urandom, $urandom};
         re1      = ($urandom_range(0, 4) != 0);
         re2      = ($urandom_range(0, 4) != 0);
         dbg_addr = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 199) == 0) begin
            #2 rst_n = 1'b0;
            #4 rst_n = 1'b1;
         end
      end

      step(); idle();
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
